map_bram_arbiter: RTL and testbench
===================================

Name: map_bram_arbiter

Overview:
Shares the single read port of the map bRAM between several read requesters: player interaction, tile renderer and enemy logic. Each cycle it picks one requester round-robin and drives its address to the bRAM. It returns the read word to the winner with a fixed-latency valid pulse. It sits between the requester modules and the map bRAM, which is clocked on the inverted system clock.

Parameters:
NUM_REQ, 3, number of requesters (2..8); index 0 is the player interaction port.
ADDR_W, 19, bRAM map address width.
DATA_W, 16, bRAM map data width.
RD_LATENCY, 1, system-clock cycles from the grant cycle until the bRAM word is captured into rdata (1..4).

Ports:
sys_clk  in  1  system clock, rising edge.
sys_rst  in  1  synchronous reset, active-high.
req  in  NUM_REQ  per-requester read request; level, held until granted.
req_addr  in  NUM_REQ*ADDR_W  packed addresses; slice i = [i*ADDR_W +: ADDR_W].
gnt  out  NUM_REQ  one-hot grant, combinational, at most one bit set.
rvalid  out  NUM_REQ  one-hot, registered; pulses for one cycle when rdata belongs to requester i.
rdata  out  DATA_W  registered read word, broadcast to all requesters.
bram_addr  out  ADDR_W  address to the map bRAM (addra).
bram_data  in  DATA_W  bRAM output (douta).

Behaviour:
- Reset (sys_rst=1 at a rising edge): rr_ptr=0, latency pipeline cleared, rvalid=0, rdata=0. While sys_rst=1, gnt=0 and bram_addr=0.
- Arbitration is combinational in cycle t:
  - Scan req starting at index rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - gnt[w]=1 and bram_addr=req_addr slice w.
  - No request: gnt=0, bram_addr=0.
- Pointer update: on a grant to w, rr_ptr <= (w+1) mod NUM_REQ at the next edge. With no grant, rr_ptr holds.
- Throughput: one grant per cycle, fully pipelined; back-to-back grants to different or the same requester are allowed.
- Requester rule:
  - Keep req and its address stable until the cycle gnt is seen.
  - In the cycle after a grant, deassert req or present the next address.
  - Dropping req before grant is legal; the request is simply abandoned.
- Latency pipeline: shift register of RD_LATENCY entries of {valid, owner index}.
  - Entry 0 is loaded at the grant edge.
  - When the last entry is valid at a rising edge, rdata <= bram_data and rvalid[owner] <= 1. Otherwise rvalid <= 0 and rdata holds.
  - Net effect: for a grant in cycle t, rvalid/rdata are visible in cycle t+RD_LATENCY.
- Ordering: responses are returned in grant order; no reordering.
- Simultaneous all-request: a full rotation serves each requester exactly once in NUM_REQ cycles.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them. Requesters must re-issue.
- An address change on a granted requester in the same cycle is not permitted (protocol violation; bench asserts on it).

Optional Feature:
MAP_ARB_PRIO0_EN
- Defined: requester 0 (player interaction) has strict priority; whenever req[0]=1 it wins. Requesters 1..NUM_REQ-1 rotate round-robin among themselves using rr_ptr, and rr_ptr is not advanced by grants to 0.
- Undefined: plain round-robin over all NUM_REQ requesters as above.

Decomposition:
- Package map_bram_pkg: MAP_ADDR_W=19, MAP_DATA_W=16, MAP_RD_LATENCY=1 constants, shared with the interact, renderer and bRAM wrapper.
- Sub-module rr_picker: combinational pointer-based first-one finder (inputs req vector and ptr; outputs one-hot grant and the winner index). It is reused by a future VGA/sprite arbiter.

Test Plan:
- Reset: hold sys_rst 3 cycles with req=3'b111 -> gnt=0, rvalid=0, rdata=0, bram_addr=0 throughout. The first grant after release goes to requester 0.
- Single read: req=3'b001, addr0=19'h00123, bRAM model returns 16'hA5A5 -> gnt[0] in cycle t; rvalid=3'b001 and rdata=16'hA5A5 in cycle t+1 (RD_LATENCY=1).
- Contention: req=3'b111 held, each requester drops req after its grant -> grant order 0,1,2 on consecutive cycles. rvalid order 001,010,100 with the matching data.
- Fairness: req=3'b111 held continuously for 30 cycles -> each requester gets exactly 10 grants, and no requester waits more than 2 cycles.
- Reset mid-flight: assert sys_rst in the cycle after a grant to requester 1 -> no rvalid[1] pulse, rr_ptr=0 after release.
- MAP_ARB_PRIO0_EN defined, req=3'b111 with req[0] held 5 cycles -> gnt=001 for 5 cycles. Then 010 and 100 alternate.

Source files
------------

// File: rtl/map_bram_pkg.sv
// ---------------------------------------------------------------------------
// map_bram_pkg
// Shared constants for the map bRAM and its clients: the interaction logic,
// tile renderer, enemy logic, bRAM wrapper and the read-port arbiter.
//
// Contents:
//   MAP_ADDR_W      map bRAM address width
//   MAP_DATA_W      map bRAM data width
//   MAP_RD_LATENCY  system-clock cycles from the grant cycle until the read
//                   word is captured into the arbiter's rdata register
//   idx_w()         width of a binary index able to address n requesters
// ---------------------------------------------------------------------------
package map_bram_pkg;

    localparam int MAP_ADDR_W     = 19;
    localparam int MAP_DATA_W     = 16;
    localparam int MAP_RD_LATENCY = 1;

    // A requester index always needs at least one bit, even for n = 2.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/map_bram_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational pointer-based first-one finder. The request vector is scanned
// starting at i_ptr and wrapping modulo NUM_REQ; the first set bit wins.
// Kept generic so other round-robin arbiters can reuse it.
//
// Parameters:
//   NUM_REQ  number of request lines
//   IDX_W    width of the pointer / winner index
// Ports:
//   i_req  [NUM_REQ-1:0]  request vector
//   i_ptr  [IDX_W-1:0]    scan start index, must be < NUM_REQ
//   o_gnt  [NUM_REQ-1:0]  one-hot grant (all zero when nothing requested)
//   o_idx  [IDX_W-1:0]    binary index of the winner (0 when o_any = 0)
//   o_any                 at least one request is set
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam int SW = IDX_W + 1;

    // w_pos[gi] is the requester examined at scan offset gi; w_rot is the
    // request vector rotated so that offset 0 is the pointer position.
    logic [IDX_W-1:0]   w_pos [NUM_REQ];
    logic [NUM_REQ-1:0] w_rot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [SW-1:0] w_sum;
            assign w_sum      = {1'b0, i_ptr} + SW'(gi);
            assign w_pos[gi]  = (w_sum >= SW'(NUM_REQ)) ? IDX_W'(w_sum - SW'(NUM_REQ))
                                                        : w_sum[IDX_W-1:0];
            assign w_rot[gi]  = i_req[w_pos[gi]];
        end
    endgenerate

    // Walk offsets from the far end back to zero so the lowest set offset,
    // i.e. the first requester after the pointer, is the one left standing.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_any = 1'b1;
                o_idx = w_pos[k];
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign o_gnt[gi] = o_any && (o_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/map_bram_arbiter.sv
// ---------------------------------------------------------------------------
// map_bram_arbiter
// Shares the single read port of the map bRAM between several requesters
// (index 0 = player interaction, then tile renderer, enemy logic, ...).
// Every cycle one requester is chosen round-robin, its address is driven to
// the bRAM, and the returned word is handed back with a one-cycle rvalid
// pulse a fixed RD_LATENCY cycles after the grant. The bRAM runs on the
// inverted system clock, so for RD_LATENCY = 1 its output is already valid at
// the rising edge that closes the grant cycle.
//
// Optional build macro:
//   MAP_ARB_PRIO0_EN  requester 0 gets strict priority; requesters
//                     1..NUM_REQ-1 rotate among themselves and grants to 0
//                     leave the round-robin pointer untouched.
//
// Parameters:
//   NUM_REQ (2..8), ADDR_W, DATA_W, RD_LATENCY (1..4)
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst    synchronous active-high reset
//   req        per-requester level request, held until granted
//   req_addr   packed addresses, slice i = [i*ADDR_W +: ADDR_W]
//   gnt        one-hot combinational grant
//   rvalid     one-hot registered response strobe
//   rdata      registered read word, broadcast to all requesters
//   bram_addr  bRAM address (addra)
//   bram_data  bRAM read data (douta)
// ---------------------------------------------------------------------------
module map_bram_arbiter
    import map_bram_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = MAP_ADDR_W,
    parameter int DATA_W     = MAP_DATA_W,
    parameter int RD_LATENCY = MAP_RD_LATENCY
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         bram_addr,
    input  logic [DATA_W-1:0]         bram_data
);

    localparam int IDX_W = idx_w(NUM_REQ);

    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   w_rr_ptr_next;
    logic [NUM_REQ-1:0] w_pick_req;
    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [IDX_W-1:0]   w_rr_idx;
    logic               w_rr_any;
    logic               w_win_any;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_prio;
    logic [ADDR_W-1:0]  w_req_addr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign w_req_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
`ifdef MAP_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation entirely, so it is hidden from the
    // picker; the pointer then only ever rotates over requesters 1..N-1.
    assign w_pick_req = req & ~NUM_REQ'(1);
    assign w_win_prio = req[0];
`else
    assign w_pick_req = req;
    assign w_win_prio = 1'b0;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req (w_pick_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    always_comb begin
        w_win_any = 1'b0;
        w_win_idx = '0;
        gnt       = '0;
        if (!sys_rst) begin
            if (w_win_prio) begin
                w_win_any = 1'b1;
                w_win_idx = '0;
                gnt       = NUM_REQ'(1);
            end else begin
                w_win_any = w_rr_any;
                w_win_idx = w_rr_idx;
                gnt       = w_rr_gnt;
            end
        end
    end

    assign bram_addr = w_win_any ? w_req_addr[w_win_idx] : '0;

    // Pointer moves just past the winner; a strict-priority grant to
    // requester 0 leaves it where it was.
    always_comb begin
        w_rr_ptr_next = r_rr_ptr;
        if (w_win_any && !w_win_prio) begin
            if (w_win_idx == IDX_W'(NUM_REQ - 1)) begin
                w_rr_ptr_next = '0;
            end else begin
                w_rr_ptr_next = w_win_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

    // ---------------------------------------------------------------------
    // Latency pipeline
    // The pipeline holds RD_LATENCY entries of {valid, owner}; the last one
    // is the rvalid/rdata register itself. Earlier entries exist only for
    // RD_LATENCY > 1, and w_tap_* is whatever feeds that last entry.
    // ---------------------------------------------------------------------
    logic               w_tap_vld;
    logic [IDX_W-1:0]   w_tap_own;
    logic [NUM_REQ-1:0] w_tap_onehot;

    generate
        if (RD_LATENCY <= 1) begin : g_lat1
            assign w_tap_vld = w_win_any;
            assign w_tap_own = w_win_idx;
        end else begin : g_latn
            localparam int DEPTH = RD_LATENCY - 1;
            logic             r_pipe_vld [DEPTH];
            logic [IDX_W-1:0] r_pipe_own [DEPTH];

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_pipe_vld[k] <= 1'b0;
                        r_pipe_own[k] <= '0;
                    end
                end else begin
                    r_pipe_vld[0] <= w_win_any;
                    r_pipe_own[0] <= w_win_idx;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_pipe_vld[k] <= r_pipe_vld[k-1];
                        r_pipe_own[k] <= r_pipe_own[k-1];
                    end
                end
            end

            assign w_tap_vld = r_pipe_vld[DEPTH-1];
            assign w_tap_own = r_pipe_own[DEPTH-1];
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_tap_onehot
            assign w_tap_onehot[gi] = w_tap_vld && (w_tap_own == IDX_W'(gi));
        end
    endgenerate

    logic [NUM_REQ-1:0] r_rvalid;
    logic [DATA_W-1:0]  r_rdata;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else if (w_tap_vld) begin
            r_rvalid <= w_tap_onehot;
            r_rdata  <= bram_data;
        end else begin
            r_rvalid <= '0;
        end
    end

    // A response that lands in the same cycle reset is raised belongs to a
    // read that reset discards, so the strobe is suppressed while reset is
    // held; the register itself is cleared at the reset edge.
    assign rvalid = sys_rst ? '0 : r_rvalid;
    assign rdata  = r_rdata;

endmodule

// File: tb/tb_map_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_map_bram_arbiter
// Directed testbench for map_bram_arbiter (NUM_REQ=3, RD_LATENCY=1).
// The map bRAM is modelled as a negative-edge register returning
// addr[15:0] ^ 16'hA486, so address 19'h00123 reads back 16'hA5A5.
// Optional build macro MAP_ARB_PRIO0_EN selects the priority-0 checks.
// ---------------------------------------------------------------------------
module tb_map_bram_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 16;

    logic                      sys_clk;
    logic                      sys_rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         bram_addr;
    logic [DATA_W-1:0]         bram_data;

    int total = 0;
    int bad   = 0;

    map_bram_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LATENCY (1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .bram_addr (bram_addr),
        .bram_data (bram_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [DATA_W-1:0] fn(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hA486;
    endfunction

    // bRAM on the inverted clock
    initial bram_data = '0;
    always @(negedge sys_clk) bram_data <= fn(bram_addr);

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    localparam logic [ADDR_W-1:0] A0 = 19'h00123;
    localparam logic [ADDR_W-1:0] A1 = 19'h45678;
    localparam logic [ADDR_W-1:0] A2 = 19'h7ABCD;

    initial begin
        int cnt [NUM_REQ];
        int last [NUM_REQ];
        int max_wait;
        logic [NUM_REQ-1:0] exp_g;
        logic [NUM_REQ-1:0] prev_g;
        logic [ADDR_W-1:0]  prev_a;

        sys_rst  = 1'b1;
        req      = 3'b111;
        req_addr = {A2, A1, A0};

        // Reset held three cycles with every requester asking
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_gnt",    32'(gnt),       32'h0);
            check("rst_rvalid", 32'(rvalid),    32'h0);
            check("rst_rdata",  32'(rdata),     32'h0);
            check("rst_addr",   32'(bram_addr), 32'h0);
            $display("reset cycle %0d gnt=%b rvalid=%b", i, gnt, rvalid);
        end

        // Contention: order 0,1,2, each drops after its grant
        sys_rst = 1'b0;
        #1;
        check("cont_gnt0",  32'(gnt),       32'h1);
        check("cont_addr0", 32'(bram_addr), 32'(A0));
        $display("contention gnt=%b addr=%h", gnt, bram_addr);
        tick(); req = 3'b110; #1;
        check("cont_gnt1",  32'(gnt),       32'h2);
        check("cont_addr1", 32'(bram_addr), 32'(A1));
        check("cont_rv0",   32'(rvalid),    32'h1);
        check("cont_rd0",   32'(rdata),     32'(fn(A0)));
        $display("contention gnt=%b rvalid=%b rdata=%h", gnt, rvalid, rdata);
        tick(); req = 3'b100; #1;
        check("cont_gnt2",  32'(gnt),       32'h4);
        check("cont_addr2", 32'(bram_addr), 32'(A2));
        check("cont_rv1",   32'(rvalid),    32'h2);
        check("cont_rd1",   32'(rdata),     32'(fn(A1)));
        $display("contention gnt=%b rvalid=%b rdata=%h", gnt, rvalid, rdata);
        tick(); req = 3'b000; #1;
        check("idle_gnt",   32'(gnt),       32'h0);
        check("idle_addr",  32'(bram_addr), 32'h0);
        check("cont_rv2",   32'(rvalid),    32'h4);
        check("cont_rd2",   32'(rdata),     32'(fn(A2)));
        $display("contention gnt=%b rvalid=%b rdata=%h", gnt, rvalid, rdata);
        tick();
        check("idle_rv",    32'(rvalid),    32'h0);
        check("hold_rd",    32'(rdata),     32'(fn(A2)));
        $display("idle rvalid=%b rdata=%h", rvalid, rdata);

        // Single read of requester 0
        req = 3'b001; #1;
        check("single_gnt",  32'(gnt),       32'h1);
        check("single_addr", 32'(bram_addr), 32'h00123);
        tick(); req = 3'b000; #1;
        check("single_rv",   32'(rvalid),    32'h1);
        check("single_rd",   32'(rdata),     32'hA5A5);
        $display("single read rvalid=%b rdata=%h", rvalid, rdata);

`ifndef MAP_ARB_PRIO0_EN
        // Pointer at 1: with req 0 and 2 pending, 2 comes first
        tick(); req = 3'b101; #1;
        check("ptr_gnt2", 32'(gnt), 32'h4);
        tick(); req = 3'b001; #1;
        check("ptr_gnt0", 32'(gnt),    32'h1);
        check("ptr_rv2",  32'(rvalid), 32'h4);
        tick(); req = 3'b000; #1;
        check("ptr_rv0",  32'(rvalid), 32'h1);
        $display("pointer test rvalid=%b", rvalid);

        // Fairness: all held 30 cycles, pointer starts at 1
        tick();
        for (int r = 0; r < NUM_REQ; r++) begin
            cnt[r]  = 0;
            last[r] = -1;
        end
        max_wait = 0;
        prev_g = '0;
        prev_a = '0;
        req = 3'b111;
        for (int k = 0; k < 30; k++) begin
            #1;
            exp_g = 3'b001 << ((1 + k) % 3);
            check("fair_gnt", 32'(gnt), 32'(exp_g));
            check("fair_rv",  32'(rvalid), 32'(prev_g));
            if (prev_g != '0) check("fair_rd", 32'(rdata), 32'(fn(prev_a)));
            for (int r = 0; r < NUM_REQ; r++) begin
                if (gnt[r]) begin
                    cnt[r]++;
                    if (k - last[r] - 1 > max_wait) max_wait = k - last[r] - 1;
                    last[r] = k;
                end
            end
            $display("fair cycle %0d gnt=%b rvalid=%b rdata=%h", k, gnt, rvalid, rdata);
            prev_g = gnt;
            prev_a = bram_addr;
            tick();
        end
        for (int r = 0; r < NUM_REQ; r++) check("fair_cnt", 32'(cnt[r]), 32'd10);
        check("fair_wait", 32'(max_wait <= 2), 32'h1);
        req = 3'b000; #1;
        check("fair_last_rv", 32'(rvalid), 32'h1);
`endif

        // Reset mid-flight after a grant to requester 1
        tick(); req = 3'b010; #1;
        check("mid_gnt1", 32'(gnt), 32'h2);
        tick(); sys_rst = 1'b1; req = 3'b000; #1;
        check("mid_rv_a", 32'(rvalid), 32'h0);
        check("mid_gnt",  32'(gnt),    32'h0);
        tick(); #1;
        check("mid_rv_b", 32'(rvalid), 32'h0);
        sys_rst = 1'b0; req = 3'b111; #1;
        check("mid_ptr0", 32'(gnt), 32'h1);
        tick(); req = 3'b000; #1;
        check("mid_rv_c", 32'(rvalid), 32'h1);
        $display("reset mid-flight rvalid=%b", rvalid);
        tick();

`ifdef MAP_ARB_PRIO0_EN
        req = 3'b111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("prio_gnt0", 32'(gnt), 32'h1);
            $display("prio cycle %0d gnt=%b", k, gnt);
            tick();
        end
`endif
        // 1 and 2 alternate once 0 is quiet
        req = 3'b110;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_g = (k % 2 == 0) ? 3'b010 : 3'b100;
            check("alt_gnt", 32'(gnt), 32'(exp_g));
            $display("alternate cycle %0d gnt=%b", k, gnt);
            tick();
        end
        req = 3'b000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
